// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: command encodings {cs_n,ras_n,cas_n,we_n},
// arbiter state encoding and default bus widths.
package sdram_pkg;

   localparam int DEF_ADDR_W = 13;
   localparam int DEF_BANK_W = 2;
   localparam int DEF_DATA_W = 16;

   localparam logic [3:0] CMD_NOP  = 4'b0111;
   localparam logic [3:0] CMD_ACT  = 4'b0011;
   localparam logic [3:0] CMD_RD   = 4'b0101;
   localparam logic [3:0] CMD_WR   = 4'b0100;
   localparam logic [3:0] CMD_PRE  = 4'b0010;
   localparam logic [3:0] CMD_AREF = 4'b0001;
   localparam logic [3:0] CMD_MRS  = 4'b0000;

   // One-hot so a corrupted state is caught by exact compares and recovered.
   localparam logic [4:0] ST_INIT  = 5'b00001;
   localparam logic [4:0] ST_ARBIT = 5'b00010;
   localparam logic [4:0] ST_AREF  = 5'b00100;
   localparam logic [4:0] ST_WRITE = 5'b01000;
   localparam logic [4:0] ST_READ  = 5'b10000;

   typedef enum logic {
      RR_WRITE = 1'b0,
      RR_READ  = 1'b1
   } rr_t;

   function automatic logic is_known_cmd(input logic [3:0] cmd);
      return (cmd == CMD_NOP) || (cmd == CMD_ACT) || (cmd == CMD_RD) ||
             (cmd == CMD_WR)  || (cmd == CMD_PRE) || (cmd == CMD_AREF) ||
             (cmd == CMD_MRS);
   endfunction

endpackage

// File: rtl/sdram_arbit_wdog.sv
// Grant watchdog: counts cycles while a grant is active and flags the cycle
// on which the grant has lasted WDOG_CYC cycles without its end flag.
module sdram_arbit_wdog #(
   parameter int WDOG_CYC = 64
) (
   input  logic sclk,
   input  logic s_rst,
   input  logic active,
   input  logic done,
   output logic expire,
   output logic err
);

   localparam int CNT_W = (WDOG_CYC > 2) ? $clog2(WDOG_CYC) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WDOG_CYC - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;

   // Idle cycles hold the count at zero, so every grant starts from zero.
   always_comb begin
      cnt_d  = active ? (cnt_q + CNT_W'(1)) : '0;
      expire = active & ~done & (cnt_q == LAST);
      err_d  = expire;
   end

   // NOTE: flops take non-blocking assignments so every always_ff samples
   // the same pre-edge values regardless of evaluation order.
   always_ff @(posedge sclk or posedge s_rst) begin
      if (s_rst) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign err = err_q;

endmodule

// File: rtl/sdram_arbit.sv
// SDRAM pin arbiter: shares cmd/addr/bank/DQ between the init, refresh,
// write and read sequencers; refresh first, write/read round-robin.
module sdram_arbit
   import sdram_pkg::*;
#(
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int BANK_W   = DEF_BANK_W,
   parameter int DATA_W   = DEF_DATA_W,
   parameter int WDOG_CYC = 64
) (
   input  logic              sclk,
   input  logic              s_rst,
   input  logic [3:0]        init_cmd,
   input  logic [ADDR_W-1:0] init_addr,
   input  logic              flag_init_end,
   input  logic              ref_req,
   output logic              ref_en,
   input  logic              flag_ref_end,
   input  logic [3:0]        ref_cmd,
   input  logic [ADDR_W-1:0] ref_addr,
   input  logic              wr_req,
   output logic              wr_en,
   input  logic              flag_wr_end,
   input  logic [3:0]        wr_cmd,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [BANK_W-1:0] wr_bank_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              wr_dq_oe,
   input  logic              rd_req,
   output logic              rd_en,
   input  logic              flag_rd_end,
   input  logic [3:0]        rd_cmd,
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic [BANK_W-1:0] rd_bank_addr,
   output logic              sdram_cke,
   output logic [3:0]        sdram_cmd,
   output logic [ADDR_W-1:0] sdram_addr,
   output logic [BANK_W-1:0] sdram_bank,
   output logic [DATA_W-1:0] sdram_dq_out,
   output logic              sdram_dq_oe,
   output logic              wdog_err
);

   logic [4:0] state_q, state_d;
   rr_t        rr_last_q, rr_last_d;
   logic       ref_en_q, ref_en_d;
   logic       wr_en_q, wr_en_d;
   logic       rd_en_q, rd_en_d;

   logic in_init, in_aref, in_write, in_read, watched;
   logic grant_end, wdog_expire;

   logic [3:0]        cmd_mux;
   logic [ADDR_W-1:0] addr_mux;
   logic [BANK_W-1:0] bank_mux;

   assign in_init  = (state_q == ST_INIT);
   assign in_aref  = (state_q == ST_AREF);
   assign in_write = (state_q == ST_WRITE);
   assign in_read  = (state_q == ST_READ);
   assign watched  = in_aref | in_write | in_read;

   // Only the granted sequencer's end flag counts; strays are ignored.
   assign grant_end = (in_aref & flag_ref_end) | (in_write & flag_wr_end) |
                      (in_read & flag_rd_end);

   sdram_arbit_wdog #(
      .WDOG_CYC (WDOG_CYC)
   ) u_wdog (
      .sclk   (sclk),
      .s_rst  (s_rst),
      .active (watched),
      .done   (grant_end),
      .expire (wdog_expire),
      .err    (wdog_err)
   );

   // NOTE: every variable written here gets a default first, so no path
   // leaves it unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_INIT: begin
            if (flag_init_end) state_d = ST_ARBIT;
         end
         ST_ARBIT: begin
            if (ref_req)                state_d = ST_AREF;
            else if (wr_req && rd_req)  state_d = (rr_last_q == RR_READ) ? ST_WRITE : ST_READ;
            else if (wr_req)            state_d = ST_WRITE;
            else if (rd_req)            state_d = ST_READ;
         end
         ST_AREF, ST_WRITE, ST_READ: begin
            if (grant_end || wdog_expire) state_d = ST_ARBIT;
         end
         default: state_d = ST_ARBIT;
      endcase

      rr_last_d = rr_last_q;
      if (in_write && (state_d != ST_WRITE)) rr_last_d = RR_WRITE;
      if (in_read && (state_d != ST_READ))   rr_last_d = RR_READ;

      ref_en_d = (state_d == ST_AREF);
      wr_en_d  = (state_d == ST_WRITE);
      rd_en_d  = (state_d == ST_READ);
   end

   always_ff @(posedge sclk or posedge s_rst) begin
      if (s_rst) begin
         state_q   <= ST_INIT;
         rr_last_q <= RR_READ;
         ref_en_q  <= 1'b0;
         wr_en_q   <= 1'b0;
         rd_en_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         rr_last_q <= rr_last_d;
         ref_en_q  <= ref_en_d;
         wr_en_q   <= wr_en_d;
         rd_en_q   <= rd_en_d;
      end
   end

   always_comb begin
      cmd_mux  = CMD_NOP;
      addr_mux = '0;
      bank_mux = '0;
      if (in_init) begin
         cmd_mux  = init_cmd;
         addr_mux = init_addr;
      end else if (in_aref) begin
         cmd_mux  = ref_cmd;
         addr_mux = ref_addr;
      end else if (in_write) begin
         cmd_mux  = wr_cmd;
         addr_mux = wr_addr;
         bank_mux = wr_bank_addr;
      end else if (in_read) begin
         cmd_mux  = rd_cmd;
         addr_mux = rd_addr;
         bank_mux = rd_bank_addr;
      end
   end

   // Reset forces idle pins immediately, even though INIT would pass init_cmd.
   assign sdram_cmd    = s_rst ? CMD_NOP : cmd_mux;
   assign sdram_addr   = s_rst ? '0 : addr_mux;
   assign sdram_bank   = s_rst ? '0 : bank_mux;
   assign sdram_dq_out = s_rst ? '0 : wr_data;
   assign sdram_dq_oe  = in_write & wr_dq_oe & ~s_rst;
   assign sdram_cke    = 1'b1;

   assign ref_en = ref_en_q;
   assign wr_en  = wr_en_q;
   assign rd_en  = rd_en_q;

endmodule
